// File: rtl/rf_write_arbiter_if.sv
// Requester/register-file handshake bundle for the register-file write arbiter.
// The master side is the requesters plus the register-file stall; the slave side is the arbiter.
interface rf_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int GW   = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [(1<<AW)-1:0] wr_sel;
  logic [GW-1:0]      grant_id;

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, wr_en, wr_addr, wr_data, wr_sel, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, wr_en, wr_addr, wr_data, wr_sel, grant_id
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters.
// One grant per cycle; the winning write is registered with a pre-decoded one-hot select.
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int GW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_write_arbiter_if.slave  bus
);
  localparam int NENT = 1 << AW;

  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   ptr_d;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [NENT-1:0] wr_sel_q;
  logic [NENT-1:0] wr_sel_d;
  logic [GW-1:0]   grant_id_q;

  logic [NREQ-1:0] grant_oh;
  logic [GW-1:0]   grant_idx;
  logic            grant_vld;
  int              cand;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Search starts at ptr and wraps explicitly modulo NREQ, so non-power-of-two NREQ never yields unused ids.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    if (rst_n && !bus.stall) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(ptr_q) + k) % NREQ;
        if (!grant_vld && bus.req_valid[cand]) begin
          grant_vld      = 1'b1;
          grant_idx      = GW'(cand);
          grant_oh[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_addr = bus.req_addr[int'(grant_idx)*AW +: AW];
    win_data = bus.req_data[int'(grant_idx)*DW +: DW];
    wr_sel_d = '0;
    if (win_addr != '0) begin
      wr_sel_d[win_addr] = 1'b1;
    end
    ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + GW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_sel_q   <= '0;
      grant_id_q <= '0;
    end else begin
      wr_en_q  <= 1'b0;
      wr_sel_q <= '0;
      if (grant_vld) begin
        // Register 0 completes the handshake and updates addr/data, but never strobes the file.
        wr_en_q    <= (win_addr != '0);
        wr_sel_q   <= wr_sel_d;
        wr_addr_q  <= win_addr;
        wr_data_q  <= win_data;
        grant_id_q <= grant_idx;
        ptr_q      <= ptr_d;
      end
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single grant, round robin, register 0, stall, drop, mid-run reset.
module tb_rf_write_arbiter;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  rf_write_arbiter_if #(.NREQ(4), .AW(5), .DW(32), .GW(2)) bus ();

  rf_write_arbiter #(.NREQ(4), .AW(5), .DW(32), .GW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester i targets register 10+i with data A000_0000+i unless a test overrides it.
  task automatic set_all();
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*5 +: 5]   = 5'(10 + i);
      bus.req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.stall     = 1'b0;
    bus.req_valid = 4'b1111;
    set_all();
    #12;
    vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL rst_ready got %b want 0000", bus.req_ready); end
    vecs++; if (bus.wr_en !== 1'b0) begin errs++; $display("FAIL rst_wr_en got %b want 0", bus.wr_en); end
    vecs++; if (bus.wr_sel !== 32'h0) begin errs++; $display("FAIL rst_wr_sel got %h want 0", bus.wr_sel); end
    vecs++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'h0 || bus.grant_id !== 2'd0) begin
      errs++; $display("FAIL rst_regs got addr %0d data %h gid %0d want 0 0 0", bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 4'b0000;
    #1;
    vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL idle_ready got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req_valid          = 4'b0010;
    bus.req_addr[5 +: 5]   = 5'd7;
    bus.req_data[32 +: 32] = 32'hDEADBEEF;
    #1;
    vecs++; if (bus.req_ready !== 4'b0010) begin errs++; $display("FAIL single_ready got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_sel !== 32'h0000_0080) begin
      errs++; $display("FAIL single_wr got en %b addr %0d sel %h want 1 7 00000080", bus.wr_en, bus.wr_addr, bus.wr_sel);
    end
    vecs++; if (bus.wr_data !== 32'hDEADBEEF || bus.grant_id !== 2'd1) begin
      errs++; $display("FAIL single_data got %h gid %0d want deadbeef 1", bus.wr_data, bus.grant_id);
    end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    vecs++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 32'h0 || bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL single_hold got en %b sel %h addr %0d data %h want 0 0 7 deadbeef",
                       bus.wr_en, bus.wr_sel, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_round_robin();
    // ptr is 2 here; a lone grant to requester 3 brings it back to 0.
    @(negedge clk);
    set_all();
    bus.req_valid = 4'b1000;
    #1;
    vecs++; if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL rr_setup_ready got %b want 1000", bus.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      vecs++; if (bus.req_ready !== 4'(1 << (c % 4))) begin
        errs++; $display("FAIL rr_ready[%0d] got %b want %b", c, bus.req_ready, 4'(1 << (c % 4)));
      end
      @(posedge clk); #1;
      vecs++; if (bus.grant_id !== 2'(c % 4) || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(10 + c % 4)
                  || bus.wr_sel !== (32'h1 << (10 + c % 4))) begin
        errs++; $display("FAIL rr_wr[%0d] got gid %0d en %b addr %0d sel %h want gid %0d en 1 addr %0d",
                         c, bus.grant_id, bus.wr_en, bus.wr_addr, bus.wr_sel, c % 4, 10 + c % 4);
      end
    end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    set_all();
    bus.req_valid          = 4'b0100;
    bus.req_addr[10 +: 5]  = 5'd0;
    bus.req_data[64 +: 32] = 32'h12345678;
    #1;
    vecs++; if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL r0_ready got %b want 0100", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 32'h0) begin
      errs++; $display("FAIL r0_strobe got en %b sel %h want 0 0", bus.wr_en, bus.wr_sel);
    end
    vecs++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'h12345678 || bus.grant_id !== 2'd2) begin
      errs++; $display("FAIL r0_regs got addr %0d data %h gid %0d want 0 12345678 2", bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    @(negedge clk);
    set_all();
    bus.req_valid = 4'b1111;
    #1;
    vecs++; if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL r0_next_ready got %b want 1000", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.grant_id !== 2'd3 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd13) begin
      errs++; $display("FAIL r0_next_wr got gid %0d en %b addr %0d want 3 1 13", bus.grant_id, bus.wr_en, bus.wr_addr);
    end
  endtask

  task automatic test_stall();
    // ptr is 0; grant requester 0 alone so the stall freezes ptr at 1.
    @(negedge clk);
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b1111;
      bus.stall     = 1'b1;
      #1;
      vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL stall_ready[%0d] got %b want 0000", c, bus.req_ready); end
      if (c == 0) begin
        vecs++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd10) begin
          errs++; $display("FAIL stall_keep got en %b addr %0d want 1 10", bus.wr_en, bus.wr_addr);
        end
      end
      @(posedge clk); #1;
      vecs++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 32'h0 || bus.grant_id !== 2'd0 || bus.wr_addr !== 5'd10) begin
        errs++; $display("FAIL stall_wr[%0d] got en %b sel %h gid %0d addr %0d want 0 0 0 10",
                         c, bus.wr_en, bus.wr_sel, bus.grant_id, bus.wr_addr);
      end
    end
    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    vecs++; if (bus.req_ready !== 4'b0010) begin errs++; $display("FAIL stall_resume_ready got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.grant_id !== 2'd1 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd11) begin
      errs++; $display("FAIL stall_resume_wr got gid %0d en %b addr %0d want 1 1 11", bus.grant_id, bus.wr_en, bus.wr_addr);
    end
  endtask

  task automatic test_hold_drop();
    // ptr is 2; last write was requester 1 (addr 11, data A0000001).
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.stall     = 1'b1;
    #1;
    vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL drop_ready got %b want 0000", bus.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    vecs++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd11 || bus.wr_data !== 32'hA000_0001 || bus.grant_id !== 2'd1) begin
      errs++; $display("FAIL drop_regs got en %b addr %0d data %h gid %0d want 0 11 a0000001 1",
                       bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    vecs++; if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL drop_ptr_ready got %b want 0100", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.grant_id !== 2'd2 || bus.wr_addr !== 5'd12) begin
      errs++; $display("FAIL drop_ptr_wr got gid %0d addr %0d want 2 12", bus.grant_id, bus.wr_addr);
    end
  endtask

  task automatic test_mid_reset();
    // ptr is 3; requester 3 wins, then reset lands while its write is pending.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    @(posedge clk); #1;
    vecs++; if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd3) begin
      errs++; $display("FAIL mrst_pre got en %b gid %0d want 1 3", bus.wr_en, bus.grant_id);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vecs++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 32'h0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'h0
                || bus.grant_id !== 2'd0) begin
      errs++; $display("FAIL mrst_clear got en %b sel %h addr %0d data %h gid %0d want all 0",
                       bus.wr_en, bus.wr_sel, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL mrst_ready got %b want 0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL mrst_first_ready got %b want 0001", bus.req_ready); end
    @(posedge clk); #1;
    vecs++; if (bus.grant_id !== 2'd0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd10) begin
      errs++; $display("FAIL mrst_first_wr got gid %0d en %b addr %0d want 0 1 10", bus.grant_id, bus.wr_en, bus.wr_addr);
    end
  endtask

  initial begin
    vecs          = 0;
    errs          = 0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.stall     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_reg0();
    test_stall();
    test_hold_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port among NREQ writeback requesters (ALU, load unit, link/branch unit, debug).
- Grants one requester per cycle with a valid/ready handshake.
- Registers the winning write and drives a pre-decoded one-hot write select (5-to-32 style) into the 32-entry register file.
- Writes to register 0 are accepted but suppressed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 5, register address width; the file holds 2**AW entries.
- DW, 32, data width.
- GW, 2, grant-id width, equal to clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  flattened destination addresses; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant (combinational); transfer occurs when valid and ready are both high.
- stall  input  1  register-file busy; blocks all grants this cycle.
- wr_en  output  1  registered write strobe.
- wr_addr  output  AW  registered write address.
- wr_data  output  DW  registered write data.
- wr_sel  output  2**AW  registered one-hot decode of wr_addr, qualified by wr_en.
- grant_id  output  GW  registered index of the requester that produced the current write.

Behaviour:
- Reset (rst_n low, asynchronous): ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, grant_id=0. req_ready is 0 while rst_n is low.
- Arbitration (combinational):
  - If stall=0, search indices ptr, ptr+1, ... mod NREQ and pick the first with req_valid set. That index g gets req_ready[g]=1; all other ready bits are 0.
  - If stall=1 or no requester is valid, req_ready is all zeros.
  - req_ready must not depend on the req_addr or req_data values.
- Transfer at edge t (req_valid[g] and req_ready[g] both high), outputs valid from t+1 for exactly one cycle:
  - wr_addr = addr_g, wr_data = data_g, grant_id = g.
  - wr_en = 1 if addr_g != 0, else 0.
  - wr_sel has bit addr_g set when wr_en=1, otherwise all zeros.
  - ptr <= (g+1) mod NREQ.
- No transfer at edge t: wr_en=0 and wr_sel=0 at t+1. wr_addr, wr_data and grant_id hold their previous values. ptr is unchanged.
- Latency: one cycle from handshake to write strobe. Throughput: one write per cycle; back-to-back grants are allowed.
- Fairness: a continuously-valid requester is granted within NREQ non-stalled cycles.
- Register-0 write: the handshake completes (ready=1) and ptr advances, but wr_en=0 and wr_sel=0. wr_addr=0 and wr_data are still updated.
- Stall: while stall=1, no grants are issued and ptr is frozen. A write already registered (wr_en=1) is not retracted by a stall arriving in the same cycle. The register file samples wr_* on the stall-free edge.
- Requesters hold addr/data stable while valid is high and ready is low. Dropping valid without a transfer is allowed.
- Reset asserted mid-operation: a write registered but not yet consumed is discarded. Outputs clear immediately, without waiting for a clock edge. The first grant after reset release goes to the lowest valid index at or above 0.
- NREQ not a power of two: pointer wrap is explicit modulo NREQ. Unused grant-id codes never appear.

Test Plan:
- Reset: hold rst_n=0 mid-cycle while wr_en=1 -> wr_en, wr_sel, wr_addr, wr_data and grant_id read 0 before the next clk edge; req_ready=0.
- Single requester: req_valid=4'b0010, addr1=5'd7, data1=32'hDEADBEEF -> req_ready=4'b0010. Next cycle: wr_en=1, wr_addr=7, wr_sel=32'h00000080, wr_data=32'hDEADBEEF, grant_id=1.
- Round robin: all four valid for 8 cycles starting from ptr=0 -> grant_id sequence 0,1,2,3,0,1,2,3. wr_en is high on all 8 following cycles.
- Register 0: requester 2 writes addr 0 with data 32'h12345678 -> ready asserted, next cycle wr_en=0, wr_sel=0. The next grant with all valid goes to requester 3.
- Stall: all valid, stall=1 for 3 cycles -> req_ready=0 and wr_en=0 throughout. After stall drops, the grant resumes at the frozen ptr index.
- Hold/drop: requester 3 valid with stall=1, then drops valid before stall clears -> no write occurs, and ptr and wr_addr/wr_data are unchanged.
